div_share_arbiter: RTL
======================

Name: div_share_arbiter

Overview:
- Shares one sequential divider datapath and its control unit between NREQ requesters.
- Picks a requester round-robin, latches its operands, and pulses the divider start.
- Waits for a completion flag, then returns the quotient and a status code to the granted requester.
- Sits between the client blocks and the divider top level. It is the only source of the divider `start`.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 10, operand and quotient width in bits.
- TO_CYC, 64, watchdog limit in cycles; used only with DIV_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- a_in  in  NREQ*WIDTH  dividends; slice i belongs to requester i.
- b_in  in  NREQ*WIDTH  divisors; slice i belongs to requester i.
- gnt  out  NREQ  one-hot, one-cycle pulse when operands are latched.
- done  out  NREQ  one-hot, one-cycle completion pulse.
- res_q  out  WIDTH  quotient; valid while any done bit is high.
- res_st  out  2  status: 00 ok, 01 divide-by-zero, 10 overflow, 11 timeout.
- arb_busy  out  1  high from grant through the response cycle.
- div_start  out  1  one-cycle start pulse to the divider.
- div_a  out  WIDTH  latched dividend.
- div_b  out  WIDTH  latched divisor.
- div_valid  in  1  divider result-valid pulse.
- div_dvz  in  1  divider divide-by-zero flag.
- div_ovf  in  1  divider overflow flag.
- div_q  in  WIDTH  divider quotient.

Behaviour:
- Reset: every output and internal register goes to 0, state goes to IDLE, round-robin pointer goes to 0.
  - Reset is asynchronous; it takes effect mid-transaction with no response issued.
  - The divider must be reset by the same rst at top level.
- States:
  - IDLE: if any req bit is set, select the winner (next below), latch a_in/b_in slices into div_a/div_b and the winner id, go to LAUNCH. Otherwise stay in IDLE.
  - LAUNCH: gnt[id]=1, div_start=1, arb_busy=1, for exactly one cycle; go to WAIT.
  - WAIT: arb_busy=1; hold div_a/div_b stable. On the first cycle any of div_valid/div_dvz/div_ovf is high, latch div_q and the status, then go to RESP.
  - RESP: done[id]=1, res_q and res_st driven, arb_busy=1; pointer becomes (id+1) mod NREQ; go to IDLE.
- Winner selection: the lowest index at or above the pointer with req set, wrapping around.
- Latency: req seen in IDLE at cycle t gives gnt at t+1. A completion flag at cycle c gives done at c+1.
- Minimum turnaround between grants to different requesters is 1 IDLE cycle after RESP.
- Status priority when flags coincide: dvz > ovf > valid.
- Operand handling:
  - Operands are captured at selection; a requester may change a_in/b_in after gnt.
  - A req bit that drops during LAUNCH/WAIT does not abort; done still pulses.
  - A req still high in the IDLE cycle after its done is treated as a new request and re-enters arbitration behind the other requesters.
- Completion flags arriving outside WAIT are ignored.
- res_q and res_st hold their last value outside RESP; only done qualifies them.

Optional Feature:
- Macro DIV_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TO_CYC with no completion flag, the arbiter goes to RESP with res_st=11 and res_q=0.
  - It must be reset by the same top-level rst.
- Undefined: there is no counter, WAIT waits forever, and status 11 is never produced.

Decomposition:
- Package div_arb_pkg holds:
  - the state encoding (IDLE=2'd0, LAUNCH=2'd1, WAIT=2'd2, RESP=2'd3);
  - the status constants ST_OK, ST_DVZ, ST_OVF, ST_TO.
- One sub-module, rr_picker: combinational round-robin priority encoder. Inputs are req and the pointer; outputs are winner id and a found flag.

Test Plan:
- Single request: req[0]=1, a=100, b=7 → gnt[0] next cycle, div_start one pulse; divider valid with q=14 → done[0], res_q=14, res_st=00.
- Simultaneous requests: req=4'b1011 held; complete each immediately → grant order 0,1,3,0; exactly one gnt/done at a time.
- Divide by zero: req[2]=1, b=0, divider raises div_dvz → done[2], res_st=01; pointer advances to 3.
- Flag coincidence: div_ovf and div_valid high in the same cycle → res_st=10.
- Reset mid-WAIT: rst asserted → all outputs 0 immediately; no done pulse; after release, req[1] → gnt[1] with pointer restarted from 0.
- With DIV_TIMEOUT_EN, TO_CYC=64: divider never completes → done at WAIT entry + 65 cycles, res_st=11, res_q=0.

Source files
------------

// File: rtl/div_arb_pkg.sv
// -----------------------------------------------------------------------------
// div_arb_pkg
// Shared definitions for the divider-sharing arbiter:
//   arb_state_t : arbiter FSM state encoding (IDLE, LAUNCH, WAIT, RESP)
//   ST_*        : two-bit response status codes returned with each result
// -----------------------------------------------------------------------------
package div_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } arb_state_t;

   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_DVZ = 2'b01;
   localparam logic [1:0] ST_OVF = 2'b10;
   localparam logic [1:0] ST_TO  = 2'b11;

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin priority encoder. Picks the lowest requester index
// at or above ptr that has its req bit set, wrapping past NREQ-1 back to 0.
// Ports:
//   req   in  NREQ  request levels
//   ptr   in  IDW   round-robin start index (always < NREQ)
//   win   out IDW   winning requester index (0 when nothing is requesting)
//   found out 1     at least one request bit is set
// -----------------------------------------------------------------------------
module rr_picker #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [IDW-1:0]  win,
   output logic            found
);

   // idx[k] is the requester sitting k places after the pointer; rot[k] is
   // its request bit, so the lowest set bit of rot is the winner.
   logic [IDW-1:0]  idx [NREQ];
   logic [NREQ-1:0] rot;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_rot
         logic [IDW:0] sum;
         assign sum     = {1'b0, ptr} + (IDW+1)'(gi);
         // ptr < NREQ and gi < NREQ, so a single subtraction is a full modulo
         assign idx[gi] = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ))
                                                   : sum[IDW-1:0];
         assign rot[gi] = req[idx[gi]];
      end
   endgenerate

   always_comb begin
      win   = '0;
      found = 1'b0;
      // Scan downwards so the lowest rotated position overwrites last
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            win   = idx[k];
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/div_share_arbiter.sv
// -----------------------------------------------------------------------------
// div_share_arbiter
// Shares one sequential divider between NREQ requesters. A round-robin winner
// has its operands latched, the divider is started with a one-cycle pulse, and
// the first completion flag seen while waiting ends the transaction with a
// one-cycle done pulse carrying quotient and status back to that requester.
//
// Optional feature (macro DIV_TIMEOUT_EN): a watchdog counts WAIT cycles and
// forces a timeout response (res_st=11, res_q=0) after TO_CYC cycles without
// a completion flag. Without the macro the arbiter waits indefinitely.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   req      in  NREQ   request levels
//   a_in     in  NREQ*W dividends, slice i = requester i
//   b_in     in  NREQ*W divisors,  slice i = requester i
//   gnt      out NREQ   one-hot pulse in the cycle the divider is started
//   done     out NREQ   one-hot completion pulse
//   res_q    out W      quotient, qualified by done
//   res_st   out 2      status: 00 ok, 01 div-by-zero, 10 overflow, 11 timeout
//   arb_busy out 1      high from grant through the response cycle
//   div_start/div_a/div_b        divider launch interface
//   div_valid/div_dvz/div_ovf/div_q  divider completion interface
// -----------------------------------------------------------------------------
module div_share_arbiter
   import div_arb_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int WIDTH  = 10,
   parameter int TO_CYC = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] a_in,
   input  logic [NREQ*WIDTH-1:0] b_in,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic [WIDTH-1:0]      res_q,
   output logic [1:0]            res_st,
   output logic                  arb_busy,
   output logic                  div_start,
   output logic [WIDTH-1:0]      div_a,
   output logic [WIDTH-1:0]      div_b,
   input  logic                  div_valid,
   input  logic                  div_dvz,
   input  logic                  div_ovf,
   input  logic [WIDTH-1:0]      div_q
);

   localparam int IDW = $clog2(NREQ);

   generate
      if (NREQ < 2 || NREQ > 8 || WIDTH < 1 || TO_CYC < 1) begin : g_param_check
         $error("div_share_arbiter: parameter out of range");
      end
   endgenerate

   arb_state_t       state_reg,  state_next;
   logic [IDW-1:0]   ptr_reg,    ptr_next;
   logic [IDW-1:0]   id_reg,     id_next;
   logic [WIDTH-1:0] div_a_reg,  div_a_next;
   logic [WIDTH-1:0] div_b_reg,  div_b_next;
   logic [WIDTH-1:0] res_q_reg,  res_q_next;
   logic [1:0]       res_st_reg, res_st_next;

`ifdef DIV_TIMEOUT_EN
   localparam int CNTW = $clog2(TO_CYC + 1);
   logic [CNTW-1:0]  cnt_reg, cnt_next;
`endif

   logic [IDW-1:0]   pick_win;
   logic             pick_found;
   logic             any_flag;

   rr_picker #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_picker (
      .req   (req),
      .ptr   (ptr_reg),
      .win   (pick_win),
      .found (pick_found)
   );

   assign any_flag = div_valid | div_dvz | div_ovf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= IDLE;
         ptr_reg    <= '0;
         id_reg     <= '0;
         div_a_reg  <= '0;
         div_b_reg  <= '0;
         res_q_reg  <= '0;
         res_st_reg <= ST_OK;
`ifdef DIV_TIMEOUT_EN
         cnt_reg    <= '0;
`endif
      end else begin
         state_reg  <= state_next;
         ptr_reg    <= ptr_next;
         id_reg     <= id_next;
         div_a_reg  <= div_a_next;
         div_b_reg  <= div_b_next;
         res_q_reg  <= res_q_next;
         res_st_reg <= res_st_next;
`ifdef DIV_TIMEOUT_EN
         cnt_reg    <= cnt_next;
`endif
      end
   end

   always_comb begin
      state_next  = state_reg;
      ptr_next    = ptr_reg;
      id_next     = id_reg;
      div_a_next  = div_a_reg;
      div_b_next  = div_b_reg;
      res_q_next  = res_q_reg;
      res_st_next = res_st_reg;
`ifdef DIV_TIMEOUT_EN
      cnt_next    = cnt_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (pick_found) begin
               id_next    = pick_win;
               div_a_next = a_in[int'(pick_win) * WIDTH +: WIDTH];
               div_b_next = b_in[int'(pick_win) * WIDTH +: WIDTH];
               state_next = LAUNCH;
            end
         end
         LAUNCH: begin
`ifdef DIV_TIMEOUT_EN
            cnt_next   = '0;
`endif
            state_next = WAIT;
         end
         WAIT: begin
            // Flag priority when several arrive together: dvz > ovf > valid
            if (any_flag) begin
               res_q_next  = div_q;
               res_st_next = div_dvz ? ST_DVZ : (div_ovf ? ST_OVF : ST_OK);
               state_next  = RESP;
            end
`ifdef DIV_TIMEOUT_EN
            else if (cnt_reg == CNTW'(TO_CYC)) begin
               res_q_next  = '0;
               res_st_next = ST_TO;
               state_next  = RESP;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
`endif
         end
         RESP: begin
            // Served requester drops to lowest priority for the next round
            ptr_next   = (id_reg == IDW'(NREQ - 1)) ? '0 : id_reg + 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_onehot
         assign gnt[gi]  = (state_reg == LAUNCH) && (id_reg == IDW'(gi));
         assign done[gi] = (state_reg == RESP)   && (id_reg == IDW'(gi));
      end
   endgenerate

   assign div_start = (state_reg == LAUNCH);
   assign arb_busy  = (state_reg != IDLE);
   assign div_a     = div_a_reg;
   assign div_b     = div_b_reg;
   assign res_q     = res_q_reg;
   assign res_st    = res_st_reg;

endmodule
